// File: rtl/mod_div_sched.sv
// Two-requester round-robin front end for a bit-serial mod-DIVISOR residue engine.
// Optional result statistics (div_cnt) are built when MOD_DIV_STAT_EN is defined.
module mod_div_sched #(
  parameter int WIDTH   = 8,
  parameter int DIVISOR = 5,
  parameter int RES_W   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [RES_W-1:0] res_rem,
  output logic             res_div,
  output logic             busy
`ifdef MOD_DIV_STAT_EN
  ,
  output logic [7:0]       div_cnt
`endif
);

  localparam int             CNT_W = $clog2(WIDTH + 1);
  localparam logic [RES_W:0] L_DIV = (RES_W + 1)'(DIVISOR);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               r_rr;
  logic               r_owner;
  logic [RES_W-1:0]   r_rem;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_shreg;
  logic               r_res_valid;
  logic               r_res_id;
  logic [RES_W-1:0]   r_res_rem;
  logic               r_res_div;

  logic               w_grant;
  logic               w_accept;
  logic               w_last;
  logic               w_res_hs;
  logic [WIDTH-1:0]   w_data;
  logic [RES_W:0]     w_t;
  logic [RES_W-1:0]   w_rem_next;

  always_comb begin
    w_state_next = r_state;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    w_accept     = 1'b0;
    // Pointer requester first, otherwise fall through to whoever is valid.
    w_grant      = r_rr ? req1_valid : !req0_valid;
    w_last       = (r_cnt == CNT_W'(1));
    w_res_hs     = r_res_valid && res_ready;
    case (r_state)
      S_IDLE: begin
        req0_ready = req0_valid && !w_grant;
        req1_ready = req1_valid && w_grant;
        w_accept   = req0_ready || req1_ready;
        if (w_accept) w_state_next = S_SHIFT;
      end
      S_SHIFT: if (w_last) w_state_next = S_DONE;
      S_DONE:  if (w_res_hs) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // t < 2*DIVISOR always, so one conditional subtract keeps the residue reduced.
  always_comb begin
    w_data     = w_grant ? req1_data : req0_data;
    w_t        = {r_rem, 1'b0} + {{RES_W{1'b0}}, r_shreg[WIDTH-1]};
    w_rem_next = (w_t >= L_DIV) ? RES_W'(w_t - L_DIV) : RES_W'(w_t);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr        <= 1'b0;
      r_owner     <= 1'b0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_shreg     <= '0;
      r_res_valid <= 1'b0;
      r_res_id    <= 1'b0;
      r_res_rem   <= '0;
      r_res_div   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_shreg <= w_data;
        r_owner <= w_grant;
        r_rem   <= '0;
        r_cnt   <= CNT_W'(WIDTH);
      end
      if (r_state == S_SHIFT) begin
        r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
        r_rem   <= w_rem_next;
        r_cnt   <= r_cnt - CNT_W'(1);
        if (w_last) begin
          r_res_valid <= 1'b1;
          r_res_rem   <= w_rem_next;
          r_res_div   <= (w_rem_next == '0);
          r_res_id    <= r_owner;
        end
      end
      if (w_res_hs) begin
        r_res_valid <= 1'b0;
        r_rr        <= ~r_owner;
      end
    end
  end

`ifdef MOD_DIV_STAT_EN
  logic [7:0] r_div_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                           r_div_cnt <= '0;
    else if (w_res_hs && r_res_div && r_div_cnt != 8'hFF) r_div_cnt <= r_div_cnt + 8'd1;
  end

  assign div_cnt = r_div_cnt;
`endif

  assign res_valid = r_res_valid;
  assign res_id    = r_res_id;
  assign res_rem   = r_res_rem;
  assign res_div   = r_res_div;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mod_div_sched.sv
// Bench for mod_div_sched: directed scenarios then random traffic, all checked
// every cycle against a transaction-level scheduler/modulo model.
module tb_mod_div_sched;
  localparam int WIDTH   = 8;
  localparam int DIVISOR = 5;
  localparam int RES_W   = 3;

  logic             clk;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_data, req1_data;
  logic             res_valid, res_ready, res_id, res_div, busy;
  logic [RES_W-1:0] res_rem;
`ifdef MOD_DIV_STAT_EN
  logic [7:0]       div_cnt;
`endif

  mod_div_sched #(.WIDTH(WIDTH), .DIVISOR(DIVISOR), .RES_W(RES_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_id     (res_id),
    .res_rem    (res_rem),
    .res_div    (res_div),
    .busy       (busy)
`ifdef MOD_DIV_STAT_EN
    ,
    .div_cnt    (div_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Transaction model: a word is owned from acceptance until its result handshake;
  // it spends WIDTH cycles computing, then waits for the consumer.
  bit m_busy = 0;
  bit m_have_res = 0;
  int m_left = 0;
  int m_rr = 0;
  int m_id = 0;
  int m_data = 0;
  int m_rem = 0;
  int m_divs = 0;
  int n_res = 0;
  int acc_cnt[2] = '{0, 0};
  int g;
  bit exp_r0, exp_r1;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_res_valid", res_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_res_rem", res_rem, 0);
      chk("rst_res_id", res_id, 0);
      chk("rst_res_div", res_div, 0);
      m_busy = 0; m_have_res = 0; m_rr = 0; m_divs = 0;
`ifdef MOD_DIV_STAT_EN
      chk("rst_div_cnt", div_cnt, 0);
`endif
    end else begin
      if (m_rr == 0) g = req0_valid ? 0 : 1;
      else           g = req1_valid ? 1 : 0;
      exp_r0 = !m_busy && req0_valid && (g == 0);
      exp_r1 = !m_busy && req1_valid && (g == 1);
      chk("req0_ready", req0_ready, exp_r0);
      chk("req1_ready", req1_ready, exp_r1);
      chk("busy", busy, m_busy);
      chk("res_valid", res_valid, m_have_res);
      if (m_have_res) begin
        chk("res_id", res_id, m_id);
        chk("res_rem", res_rem, m_rem);
        chk("res_div", res_div, m_rem == 0);
      end
`ifdef MOD_DIV_STAT_EN
      chk("div_cnt", div_cnt, m_divs);
`endif
      if (!m_busy) begin
        if (exp_r0 || exp_r1) begin
          m_busy = 1;
          m_left = WIDTH;
          m_id   = g;
          m_data = (g == 1) ? int'(req1_data) : int'(req0_data);
          m_rem  = m_data % DIVISOR;
          acc_cnt[g]++;
        end
      end else if (!m_have_res) begin
        m_left--;
        if (m_left == 0) m_have_res = 1;
      end else if (res_ready) begin
        $display("result %0d: id=%0d data=%0d rem=%0d div=%0d (dut rem=%0d)",
                 n_res, m_id, m_data, m_rem, m_rem == 0, res_rem);
        n_res++;
        if (m_rem == 0 && m_divs < 255) m_divs++;
        m_rr = (m_id == 0) ? 1 : 0;
        m_busy = 0;
        m_have_res = 0;
      end
    end
  end

  task automatic send(input int r, input int d);
    int base = acc_cnt[r];
    if (r == 0) begin req0_valid = 1'b1; req0_data = WIDTH'(d); end
    else        begin req1_valid = 1'b1; req1_data = WIDTH'(d); end
    for (int i = 0; i < 200 && acc_cnt[r] == base; i++) begin
      @(posedge clk); #1;
    end
    chk("accept_timeout", acc_cnt[r] != base, 1);
    if (r == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  task automatic wait_res(input int tgt);
    for (int i = 0; i < 400 && n_res < tgt; i++) begin
      @(posedge clk); #1;
    end
    chk("result_timeout", n_res >= tgt, 1);
  endtask

  int base;
  int pa0, pa1;

  initial begin
    rst_n = 1'b0; res_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    base = n_res; send(0, 35); wait_res(base + 1);

    // Reset while the word is still shifting: no result may ever appear for it.
    base = n_res; send(0, 35);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_valid", res_valid, 0);
    chk("async_rst_rem", res_rem, 0);
    chk("async_rst_id", res_id, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("no_result_after_rst", n_res, base);
    base = n_res; send(0, 35); wait_res(base + 1);

    base = n_res; send(1, 37); wait_res(base + 1);

    base = n_res;
    req0_valid = 1'b1; req0_data = 8'd10;
    req1_valid = 1'b1; req1_data = 8'd11;
    wait_res(base + 4);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Consumer stalls while requester 1 waits.
    base = n_res;
    res_ready = 1'b0;
    send(0, 123);
    req1_valid = 1'b1; req1_data = 8'd77;
    repeat (WIDTH + 6) @(posedge clk);
    #1 res_ready = 1'b1;
    wait_res(base + 1);
    pa1 = acc_cnt[1];
    for (int i = 0; i < 20 && acc_cnt[1] == pa1; i++) begin
      @(posedge clk); #1;
    end
    req1_valid = 1'b0;
    wait_res(base + 2);

    base = n_res; send(0, 0);   wait_res(base + 1);
    base = n_res; send(1, 255); wait_res(base + 1);
    base = n_res; send(0, 254); wait_res(base + 1);

    pa0 = acc_cnt[0]; pa1 = acc_cnt[1];
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (acc_cnt[0] != pa0 || !req0_valid) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_data  = WIDTH'($urandom_range(0, 255));
      end else if ($urandom_range(0, 7) == 0) begin
        req0_valid = 1'b0;
      end
      if (acc_cnt[1] != pa1 || !req1_valid) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_data  = WIDTH'($urandom_range(0, 255));
      end else if ($urandom_range(0, 7) == 0) begin
        req1_valid = 1'b0;
      end
      pa0 = acc_cnt[0]; pa1 = acc_cnt[1];
      res_ready = ($urandom_range(0, 3) != 0);
    end

    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    for (int i = 0; i < 100 && m_busy; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_timeout", m_busy, 0);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
